// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Function : HI/LO multiply/divide unit with multi-cycle busy window and stall
//  Revision : 1.0
// ============================================================================
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  xaluop,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [31:0] hilo_out,
   output logic        busy,
   output logic        start,
   output logic        md_stall
);

   localparam logic [3:0] c_OP_NONE  = 4'd0;
   localparam logic [3:0] c_OP_MTLO  = 4'd1;
   localparam logic [3:0] c_OP_MTHI  = 4'd2;
   localparam logic [3:0] c_OP_DIVU  = 4'd3;
   localparam logic [3:0] c_OP_DIV   = 4'd4;
   localparam logic [3:0] c_OP_MULTU = 4'd5;
   localparam logic [3:0] c_OP_MULT  = 4'd6;
   localparam logic [3:0] c_OP_MFLO  = 4'd7;
   localparam logic [3:0] c_OP_MFHI  = 4'd8;

   localparam int c_MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_CW   = $clog2(c_MAXC + 1);
   localparam logic [c_CW-1:0] c_MULT_LEN = c_CW'(MULT_CYCLES);
   localparam logic [c_CW-1:0] c_DIV_LEN  = c_CW'(DIV_CYCLES);
   localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);

   logic [31:0]      r_hi, r_lo, r_res_hi, r_res_lo;
   logic             r_res_wr, r_busy;
   logic [c_CW-1:0]  r_cnt;

   logic [3:0]        w_op;
   logic              w_idle, w_is_md, w_is_mul;
   logic [63:0]       w_prod_u;
   logic signed [63:0] w_prod_s;
   logic [31:0]       w_b_safe, w_a_mag, w_b_mag, w_sq, w_sr;
   logic [31:0]       w_res_hi, w_res_lo;
   logic              w_res_wr;

   assign w_op     = (xaluop > c_OP_MFHI) ? c_OP_NONE : xaluop;
   assign w_idle   = (r_cnt == '0);
   assign w_is_md  = (w_op >= c_OP_DIVU) && (w_op <= c_OP_MULT);
   assign w_is_mul = (w_op == c_OP_MULTU) || (w_op == c_OP_MULT);

   assign w_prod_u = {32'd0, rs_data} * {32'd0, rt_data};
   assign w_prod_s = $signed(rs_data) * $signed(rt_data);

   // Divisor forced to 1 when zero so the dividers never see x; the write is suppressed instead.
   assign w_b_safe = (rt_data == 32'd0) ? 32'd1 : rt_data;
   assign w_a_mag  = rs_data[31]  ? (32'd0 - rs_data)  : rs_data;
   assign w_b_mag  = w_b_safe[31] ? (32'd0 - w_b_safe) : w_b_safe;
   assign w_sq     = w_a_mag / w_b_mag;
   assign w_sr     = w_a_mag % w_b_mag;

   always_comb begin
      w_res_hi = 32'd0;
      w_res_lo = 32'd0;
      w_res_wr = 1'b1;
      case (w_op)
         c_OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
         c_OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
         c_OP_DIVU: begin
            w_res_lo = rs_data / w_b_safe;
            w_res_hi = rs_data % w_b_safe;
            w_res_wr = (rt_data != 32'd0);
         end
         c_OP_DIV: begin
            w_res_lo = (rs_data[31] ^ rt_data[31]) ? (32'd0 - w_sq) : w_sq;
            w_res_hi = rs_data[31] ? (32'd0 - w_sr) : w_sr;
            w_res_wr = (rt_data != 32'd0);
         end
         default: ;
      endcase
   end

   assign start    = w_idle & w_is_md;
   assign busy     = r_busy;
   assign md_stall = (r_busy | start) & (w_op != c_OP_NONE);

   always_comb begin
      hilo_out = 32'd0;
      if (w_idle && (w_op == c_OP_MFHI)) hilo_out = r_hi;
      else if (w_idle && (w_op == c_OP_MFLO)) hilo_out = r_lo;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_res_hi <= 32'd0;
         r_res_lo <= 32'd0;
         r_res_wr <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else if (w_idle) begin
         if (w_is_md) begin
            r_res_hi <= w_res_hi;
            r_res_lo <= w_res_lo;
            r_res_wr <= w_res_wr;
            r_cnt    <= w_is_mul ? c_MULT_LEN : c_DIV_LEN;
            r_busy   <= 1'b1;
         end else if (w_op == c_OP_MTHI) begin
            r_hi <= rs_data;
         end else if (w_op == c_OP_MTLO) begin
            r_lo <= rs_data;
         end
      end else begin
         r_cnt  <= r_cnt - c_ONE;
         r_busy <= (r_cnt != c_ONE);
         if ((r_cnt == c_ONE) && r_res_wr) begin
            r_hi <= r_res_hi;
            r_lo <= r_res_lo;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_unit
//  Function : directed self-checking bench for md_unit
//  Revision : 1.0
// ============================================================================
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  xaluop = 4'd0;
   logic [31:0] rs_data = 32'd0;
   logic [31:0] rt_data = 32'd0;
   logic [31:0] hilo_out;
   logic        busy, start, md_stall;

   int n_chk = 0;
   int n_err = 0;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .xaluop   (xaluop),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .hilo_out (hilo_out),
      .busy     (busy),
      .start    (start),
      .md_stall (md_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   // Issue a mult/div at a negedge and follow it through its busy window.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int n);
      xaluop = op; rs_data = a; rt_data = b;
      #1;
      chk({tag, "_start"}, {31'd0, start}, 32'd1);
      chk({tag, "_stall0"}, {31'd0, md_stall}, 32'd1);
      chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      xaluop = 4'd0;
      for (int i = 0; i < n; i++) begin
         #1;
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         chk({tag, "_nostart"}, {31'd0, start}, 32'd0);
         @(negedge clk);
      end
      #1;
      chk({tag, "_done"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic rd(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      xaluop = 4'd8;
      #1;
      chk({tag, "_mfhi"}, hilo_out, exp_hi);
      chk({tag, "_mfhi_stall"}, {31'd0, md_stall}, 32'd0);
      xaluop = 4'd7;
      #1;
      chk({tag, "_mflo"}, hilo_out, exp_lo);
      xaluop = 4'd0;
   endtask

   task automatic wr(input logic [3:0] op, input logic [31:0] a);
      xaluop = op; rs_data = a;
      #1;
      chk("mt_nostall", {31'd0, md_stall}, 32'd0);
      @(negedge clk);
      xaluop = 4'd0;
   endtask

   initial begin
      xaluop = 4'd8;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hilo_out, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      xaluop = 4'd0;
      @(negedge clk);

      run_op("mult", 4'd6, 32'hFFFF_FFFE, 32'd3, 5);
      rd("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      @(negedge clk);

      run_op("multu", 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
      rd("multu", 32'hFFFF_FFFE, 32'h0000_0001);
      @(negedge clk);

      run_op("div", 4'd4, 32'hFFFF_FFF9, 32'd2, 10);
      rd("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      @(negedge clk);

      wr(4'd2, 32'h1234_5678);
      rd("mthi", 32'h1234_5678, 32'hFFFF_FFFD);
      @(negedge clk);

      wr(4'd2, 32'h0000_0011);
      wr(4'd1, 32'h0000_0022);
      run_op("divu0", 4'd3, 32'd7, 32'd0, 10);
      rd("divu0", 32'h0000_0011, 32'h0000_0022);
      @(negedge clk);

      run_op("divovf", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      rd("divovf", 32'h0000_0000, 32'h8000_0000);
      @(negedge clk);

      // mflo held throughout a divu busy window: 100 / 7 = 14 rem 2
      xaluop = 4'd3; rs_data = 32'd100; rt_data = 32'd7;
      #1;
      chk("mfdiv_start", {31'd0, start}, 32'd1);
      @(negedge clk);
      xaluop = 4'd7;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("mfdiv_stall", {31'd0, md_stall}, 32'd1);
         chk("mfdiv_hilo", hilo_out, 32'd0);
         @(negedge clk);
      end
      #1;
      chk("mfdiv_idle_stall", {31'd0, md_stall}, 32'd0);
      chk("mfdiv_idle_lo", hilo_out, 32'd14);
      xaluop = 4'd0;
      rd("mfdiv", 32'd2, 32'd14);
      @(negedge clk);

      // mtlo while busy with a mult is ignored: 6 * 7 = 42
      xaluop = 4'd6; rs_data = 32'd6; rt_data = 32'd7;
      @(negedge clk);
      xaluop = 4'd1; rs_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("mtlo_busy_stall", {31'd0, md_stall}, 32'd1);
         @(negedge clk);
      end
      xaluop = 4'd0;
      rd("mtlo_busy", 32'd0, 32'd42);
      @(negedge clk);

      // reset in the third busy cycle of a mult
      xaluop = 4'd6; rs_data = 32'd3; rt_data = 32'd4;
      @(negedge clk);
      xaluop = 4'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      rd("rstmid", 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      chk("rstpost_busy", {31'd0, busy}, 32'd0);
      rd("rstpost", 32'd0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- HI/LO multiply/divide unit in the EX stage.
- Consumes the 4-bit xaluop produced by the instruction decoder, plus the forwarded rs/rt operands.
- Runs mult/multu/div/divu as multi-cycle operations against a pair of architectural HI/LO registers.
- Serves mfhi/mflo reads and mthi/mtlo writes, and raises a stall request to the hazard unit while a result is pending.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state.
- xaluop  input  4  operation code: 0 none, 1 mtlo, 2 mthi, 3 divu, 4 div, 5 multu, 6 mult, 7 mflo, 8 mfhi; 9-15 treated as 0.
- rs_data  input  32  operand A (dividend/multiplicand, or mthi/mtlo source).
- rt_data  input  32  operand B (divisor/multiplier).
- hilo_out  output  32  mfhi -> HI, mflo -> LO, otherwise 0; combinational.
- busy  output  1  high while an operation is in flight; registered.
- start  output  1  combinational pulse: a mult/div is accepted this cycle.
- md_stall  output  1  (busy | start) & (xaluop != 0); the hazard unit holds the issuing stage while this is high.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, counter=0, busy=0, pending results=0. hilo_out and start follow their combinational definitions.
- Idle (counter==0), xaluop in {3,4,5,6}:
  - start=1.
  - At the clock edge: latch result_hi/result_lo computed from rs_data/rt_data.
  - counter <= MULT_CYCLES for multu/mult, DIV_CYCLES for divu/div.
- Busy (counter!=0):
  - busy=1 and counter decrements each edge.
  - On the edge where counter==1: HI<=result_hi, LO<=result_lo, counter<=0.
  - Op accepted at the edge ending cycle T: busy is high in cycles T+1..T+N, and the new HI/LO are visible in cycle T+N+1.
- While busy, every nonzero xaluop (including mthi/mtlo/mfhi/mflo and new mult/div) is ignored and asserts md_stall. The instruction is re-presented after busy drops.
- A new mult/div in the cycle busy drops is accepted normally (counter==0 that cycle).
- Start cycle: md_stall=1 for the accepting instruction. The hazard unit treats start as the acceptance acknowledgement and advances it; the follow-on cycles stall via busy.
- mthi/mtlo while idle: HI<=rs_data or LO<=rs_data at the edge; the other register is unchanged; no busy.
- mfhi/mflo while idle: hilo_out = current HI/LO, no stall.
- Arithmetic:
  - multu: {HI,LO} = zero-extended 32x32 -> 64-bit product.
  - mult: two's-complement signed 64-bit product.
  - divu: LO = unsigned quotient, HI = unsigned remainder.
  - div: quotient truncated toward zero; remainder takes the sign of the dividend; 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0 (div or divu): the full busy duration still elapses; HI and LO are left unchanged.
- Reset asserted mid-operation: the operation is abandoned, counter=0, busy=0 immediately, HI=LO=0; no late writeback after reset deasserts.
- No internal pipelining: at most one operation in flight.

Test Plan:
- mult rs=0xFFFFFFFE(-2), rt=3 -> start=1 one cycle, busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi/mflo read those values.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- div rs=0xFFFFFFF9(-7), rt=2 -> busy 10 cycles, LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); divu rs=7, rt=0 with HI=0x11, LO=0x22 beforehand -> both unchanged after 10 cycles.
- mflo presented during a div busy window -> md_stall=1 every busy cycle, hilo_out=0; in the first idle cycle, md_stall=0 and hilo_out shows the new LO.
- mthi rs=0x12345678 while idle -> HI=0x12345678 next cycle, LO unchanged; mtlo while busy -> ignored, md_stall=1.
- reset pulled low in cycle 3 of a mult -> busy=0 and HI=LO=0 immediately, and both stay 0 after reset releases with xaluop=0.
